// File: rtl/seg_scan_drv.sv
// seg_scan_drv: six-digit multiplexed seven-segment driver with a per-frame BCD shadow latch.
// Define SEG_LZB_EN to blank leading zeros on digits 5..3.
module seg_scan_drv #(
  parameter int unsigned SCAN_DIV  = 49_999,
  parameter int unsigned BLANK_CYC = 1_000,
  parameter bit          ACT_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] din,
  output logic [7:0]  seg,
  output logic [5:0]  sel,
  output logic        frame_done
);
  localparam int PW = $clog2(SCAN_DIV + 1);
  localparam logic [PW-1:0] P_MAX = PW'(SCAN_DIV);
  localparam logic [PW-1:0] P_BLK = PW'(BLANK_CYC);
  localparam logic [7:0] SEG_OFF = {8{ACT_LOW}};
  localparam logic [5:0] SEL_OFF = {6{ACT_LOW}};
  logic [PW-1:0] p_q, p_d;
  logic [2:0] idx_q, idx_d;
  logic [23:0] shadow_q, shadow_d;
  logic [7:0] seg_q, seg_d;
  logic [5:0] sel_q, sel_d;
  logic fd_q, fd_d;
  logic tick, frame_end, blank, dig_off;
  logic [3:0] nib;
  logic [6:0] dec;
  logic [7:0] lz;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hF: return 7'h00;
      default: return 7'h40;
    endcase
  endfunction

`ifdef SEG_LZB_EN
  function automatic logic zf(input logic [3:0] n);
    return n == 4'h0 || n == 4'hF;
  endfunction
  // Scan stops at digit 2 so the units of seconds and everything below always show.
  assign lz = {2'b00,
               shadow_q[23:20] == 4'h0,
               shadow_q[19:16] == 4'h0 && zf(shadow_q[23:20]),
               shadow_q[15:12] == 4'h0 && zf(shadow_q[23:20]) && zf(shadow_q[19:16]),
               3'b000};
`else
  assign lz = '0;
`endif

  assign tick = p_q == P_MAX;
  assign frame_end = tick && idx_q == 3'd5;
  assign nib = 4'(shadow_q >> {idx_q, 2'b00});

  always_comb begin
    p_d = tick ? '0 : p_q + 1'b1;
    idx_d = tick ? (idx_q == 3'd5 ? 3'd0 : idx_q + 3'd1) : idx_q;
    shadow_d = frame_end ? din : shadow_q;
    fd_d = frame_end;
    dig_off = nib == 4'hF || lz[idx_q];
    dec = dig_off ? 7'h00 : decode(nib);
    blank = p_q < P_BLK;
    seg_d = SEG_OFF ^ (blank ? 8'h00 : {!dig_off && (idx_q == 3'd4 || idx_q == 3'd2), dec});
    sel_d = SEL_OFF ^ (blank ? 6'h00 : 6'b1 << idx_q);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p_q <= '0;
      idx_q <= '0;
      shadow_q <= 24'hFFFFFF;
      fd_q <= 1'b0;
      seg_q <= SEG_OFF;
      sel_q <= SEL_OFF;
    end else begin
      p_q <= p_d;
      idx_q <= idx_d;
      shadow_q <= shadow_d;
      fd_q <= fd_d;
      seg_q <= seg_d;
      sel_q <= sel_d;
    end

  assign seg = seg_q;
  assign sel = sel_q;
  assign frame_done = fd_q;
endmodule
